// File: rtl/load_store_unit.sv
// load_store_unit: core load/store requests to a single-beat word bus with lane steering and timeout
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_op,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  fault,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
  stateT state;
  logic req, badAccess, timedOut;
  logic [3:0] reqBe;
  logic [DATA_WIDTH-1:0] reqWdata, loadData, rdataReg;
  logic [7:0] laneByte;
  logic [15:0] laneHalf;
  logic [2:0] opReg;
  logic [1:0] offReg;
  logic [CW-1:0] cnt;
  // request decode, lane steering for stores and lane extraction for loads
  always_comb begin
    req = mem_read | mem_write;
    badAccess = (mem_op[1:0] == 2'b11) || (mem_op == 3'b110) ||
                (mem_op[1:0] == 2'b01 && addr[0]) || (mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00);
    reqBe = mem_op[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
            mem_op[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    reqWdata = mem_op[1:0] == 2'b00 ? {(DATA_WIDTH/8){wdata[7:0]}} :
               mem_op[1:0] == 2'b01 ? {(DATA_WIDTH/16){wdata[15:0]}} : wdata;
    laneByte = bus_rdata[{offReg, 3'b000} +: 8];
    laneHalf = bus_rdata[{offReg[1], 4'b0000} +: 16];
    loadData = opReg[1:0] == 2'b00 ? {{(DATA_WIDTH-8){laneByte[7] & ~opReg[2]}}, laneByte} :
               opReg[1:0] == 2'b01 ? {{(DATA_WIDTH-16){laneHalf[15] & ~opReg[2]}}, laneHalf} : bus_rdata;
    stall = rst && ((state == IDLE && req && !badAccess) || state == BUSY);
    fault = rst && ((state == IDLE && req && badAccess) || (state == DONE && timedOut));
    rdata = (state == IDLE && req && badAccess) ? '0 : rdataReg;
  end
  // transaction FSM: latch the request, wait for ack or timeout, present the result for one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bus_valid <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      rdataReg <= '0;
      cnt <= '0;
      timedOut <= 1'b0;
      opReg <= '0;
      offReg <= '0;
    end else begin
      case (state)
        IDLE: if (req && !badAccess) begin
          state <= BUSY;
          bus_valid <= 1'b1;
          bus_we <= mem_write;
          bus_addr <= {addr[DATA_WIDTH-1:2], 2'b00};
          bus_be <= reqBe;
          bus_wdata <= reqWdata;
          opReg <= mem_op;
          offReg <= addr[1:0];
          cnt <= '0;
          rdataReg <= '0;
        end
        BUSY: if (bus_ack) begin
          state <= DONE;
          bus_valid <= 1'b0;
          if (!bus_we) rdataReg <= loadData;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state <= DONE;
          bus_valid <= 1'b0;
          rdataReg <= '0;
          timedOut <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          timedOut <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit
module tb_load_store_unit;
  localparam int TO = 16;
  logic clk = 0, rst = 0, mem_read = 0, mem_write = 0, bus_ack = 0;
  logic [2:0] mem_op = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic stall, fault, bus_valid, bus_we;
  logic [3:0] bus_be;
  int nTests = 0, nFail = 0;

  typedef struct {int kind; logic [31:0] baddr, wd, rd; logic [3:0] be; bit we, flt; int lat;} expT;
  expT q[$];

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    nTests++;
    if (a !== e) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // reference: kind 0 good, 1 bad access, 2 aborted by reset
  function automatic expT model(bit wr, logic [2:0] op, logic [31:0] a, wd, int delay, logic [31:0] brd, bit ab);
    expT e;
    int sz = op % 4;
    logic [31:0] v = brd;
    bit bad = op == 3 || op == 6 || op == 7 || (sz == 1 && a % 2 == 1) || (sz == 2 && a % 4 != 0);
    e.kind = bad ? 1 : ab ? 2 : 0;
    e.we = wr;
    e.baddr = a - a % 4;
    e.be = sz == 0 ? 4'(1 << (a % 4)) : sz == 1 ? 4'(3 << (a & 2)) : 4'hF;
    e.wd = sz == 0 ? wd[7:0] * 32'h01010101 : sz == 1 ? wd[15:0] * 32'h00010001 : wd;
    if (sz == 0) begin
      v = (brd >> (8 * (a % 4))) & 255;
      if (op < 4 && v >= 128) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (brd >> (8 * (a & 2))) & 65535;
      if (op < 4 && v >= 32768) v = v | 32'hFFFF0000;
    end
    e.flt = delay >= TO;
    e.rd = e.flt ? 0 : v;
    e.lat = e.flt ? TO + 1 : delay + 2;
    return e;
  endfunction

  task automatic doAccess(input bit rd, wr, input logic [2:0] op, input logic [31:0] a, wd,
                          input int delay, input logic [31:0] brd, input bit ab, input int k);
    expT e = model(wr, op, a, wd, delay, brd, ab);
    q.push_back(e);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_op = op; addr = a; wdata = wd; bus_ack = 0; bus_rdata = brd;
    if (e.kind == 1) begin
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
    end else if (e.kind == 2) begin
      repeat (k) begin @(posedge clk); #1; bus_ack = 0; end
      @(posedge clk); #1;
      rst = 0; mem_read = 0; mem_write = 0;
      @(posedge clk); #1;
      rst = 1; bus_ack = 1;
      @(posedge clk); #1;
      bus_ack = 0;
    end else begin
      for (int j = 0; ; j++) begin
        @(posedge clk); #1;
        bus_ack = (j == delay);
        @(negedge clk);
        if (!stall) break;
        if (j > TO + 4) begin
          chk("done_timeout", 1, 0);
          break;
        end
      end
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0; bus_ack = 0;
    end
  endtask

  // monitor: pops the scoreboard at request faults, completions and reset release
  initial begin
    int cyc = 0, start = 0;
    bit prevStall = 0, sawRst = 0, firstBusy = 0;
    expT e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_quiet", {stall, fault}, 0);
        sawRst = 1;
        prevStall = 0;
      end else begin
        if (sawRst) begin
          sawRst = 0;
          chk("rst_bus", {bus_valid, bus_we, bus_be}, 0);
          chk("rst_addr", bus_addr, 0);
          chk("rst_wdata", bus_wdata, 0);
          chk("rst_rdata", rdata, 0);
          if (q.size() != 0 && q[0].kind == 2) void'(q.pop_front());
        end
        if (!prevStall && stall) begin
          start = cyc;
          firstBusy = 1;
          chk("req_fault", fault, 0);
        end else if (prevStall && stall) begin
          if (q.size() == 0) chk("busy_expected", 0, 1);
          else begin
            e = q[0];
            chk("busy_hold", {bus_valid, bus_we, bus_be, bus_addr}, {1'b1, e.we, e.be, e.baddr});
            if (firstBusy && e.we) chk("bus_wdata", bus_wdata, e.wd);
            firstBusy = 0;
          end
        end else if (prevStall && !stall) begin
          if (q.size() == 0) chk("done_expected", 0, 1);
          else begin
            e = q.pop_front();
            chk("done_kind", e.kind, 0);
            chk("latency", cyc - start, e.lat);
            chk("done_fault", fault, e.flt);
            chk("done_valid", bus_valid, 0);
            if (!e.we) chk("rdata", rdata, e.rd);
          end
        end else if (!stall && fault) begin
          if (q.size() == 0) chk("bad_expected", 0, 1);
          else begin
            e = q.pop_front();
            chk("bad_kind", e.kind, 1);
            chk("bad_rdata", rdata, 0);
            chk("bad_valid", bus_valid, 0);
          end
        end
        if (!prevStall && !(mem_read | mem_write)) chk("idle_quiet", {stall, fault, bus_valid}, 0);
        prevStall = stall;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    doAccess(1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0);
    doAccess(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FFFFFF, 0, 0);
    doAccess(1, 0, 3'b100, 32'h103, 0, 2, 32'h80FFFFFF, 0, 0);
    doAccess(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, 0);
    doAccess(1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 0);
    doAccess(1, 0, 3'b010, 32'h200, 0, 99, 32'h12345678, 0, 0);
    doAccess(1, 0, 3'b101, 32'h202, 0, TO - 1, 32'h8001_7FFF, 0, 0);
    doAccess(1, 0, 3'b010, 32'h300, 0, 99, 32'h55555555, 1, 2);
    doAccess(1, 1, 3'b000, 32'h401, 32'h000000A5, 0, 32'hFFFFFFFF, 0, 0);
    doAccess(1, 0, 3'b001, 32'h402, 0, 0, 32'h8001_7FFF, 0, 0);
    doAccess(0, 1, 3'b011, 32'h400, 0, 0, 0, 0, 0);
    for (int i = 0; i < 250; i++) begin
      int rw = $urandom_range(1, 3);
      bit ab = $urandom_range(0, 19) == 0;
      int dl = $urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 2);
      doAccess(rw[0], rw[1], 3'($urandom_range(0, 7)), $urandom, $urandom, ab ? 99 : dl,
               $urandom, ab, $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; bus_ack = 1'($urandom); end
    end
    repeat (3) @(posedge clk);
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
